// File: rtl/tb_lane_cnt_rdout.sv
// Test-beam lane monitor: per-lane event counters with trigger-driven snapshot
// and framed readout (header, one word per lane, trailer) into a backpressured FIFO.
module tb_lane_cnt_rdout #(
  parameter int LANES_G         = 576,
  parameter int CNT_WIDTH_G     = 32,
  parameter int READOUT_WIDTH_G = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [LANES_G-1:0]         monitor_i,
  input  logic                       trig_i,
  input  logic                       clr_on_snap_i,
  input  logic                       sat_mode_i,
  input  logic                       fifo_full_i,
  input  logic                       fifo_almst_full_i,
  output logic                       fifo_wr_o,
  output logic [READOUT_WIDTH_G-1:0] fifo_data_o,
  output logic                       busy_o,
  output logic                       trig_drop_o
);

  localparam int IDX_W = (LANES_G > 1) ? $clog2(LANES_G) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES_G - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_TRL  = 2'd3;

  logic [CNT_WIDTH_G-1:0]     cnt_q    [LANES_G];
  logic [CNT_WIDTH_G-1:0]     shadow_q [LANES_G];
  logic [LANES_G-1:0]         lane_ovf;
  logic                       ovf_q;
  logic                       ovf_snap_q;
  logic [15:0]                frame_id_q;
  logic [IDX_W-1:0]           idx_q;
  logic [IDX_W-1:0]           idx_nxt;
  logic [1:0]                 state_q;
  logic [READOUT_WIDTH_G-1:0] data_q;
  logic                       drop_q;
  logic                       snap;
  logic                       wr_ok;

  function automatic logic [READOUT_WIDTH_G-1:0] hdr_word(input logic [11:0] fid);
    logic [READOUT_WIDTH_G-1:0] w;
    w        = '0;
    w[31:28] = 4'hA;
    w[27:16] = fid;
    w[15:0]  = 16'(LANES_G);
    return w;
  endfunction

  function automatic logic [READOUT_WIDTH_G-1:0] trl_word(input logic ovf, input logic [15:0] fid);
    logic [READOUT_WIDTH_G-1:0] w;
    w        = '0;
    w[31:28] = 4'h5;
    w[27]    = ovf;
    w[15:0]  = fid;
    return w;
  endfunction

  assign snap    = (state_q == S_IDLE) && trig_i;
  assign wr_ok   = (state_q != S_IDLE) && !fifo_full_i && !fifo_almst_full_i;
  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    lane_ovf = '0;
    for (int k = 0; k < LANES_G; k++) begin
      lane_ovf[k] = monitor_i[k] && (cnt_q[k] == '1);
    end
  end

  // A snapshot with clear restarts each lane at its cycle-t event, so no event is lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < LANES_G; k++) begin
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LANES_G; k++) begin
        if (snap) begin
          shadow_q[k] <= cnt_q[k];
        end
        if (snap && clr_on_snap_i) begin
          cnt_q[k] <= CNT_WIDTH_G'(monitor_i[k]);
        end else if (lane_ovf[k]) begin
          cnt_q[k] <= sat_mode_i ? cnt_q[k] : '0;
        end else if (monitor_i[k]) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // data_q is preloaded with the word of the state being entered, so it is
  // valid in the same cycle the write strobe can first fire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      frame_id_q <= '0;
      ovf_q      <= 1'b0;
      ovf_snap_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= trig_i && (state_q != S_IDLE);
      if (snap) begin
        ovf_snap_q <= ovf_q | (|lane_ovf);
        ovf_q      <= 1'b0;
      end else begin
        ovf_q <= ovf_q | (|lane_ovf);
      end
      case (state_q)
        S_IDLE: begin
          if (trig_i) begin
            state_q <= S_HDR;
            data_q  <= hdr_word(frame_id_q[11:0]);
          end
        end
        S_HDR: begin
          if (wr_ok) begin
            state_q <= S_DATA;
            idx_q   <= '0;
            data_q  <= READOUT_WIDTH_G'(shadow_q[0]);
          end
        end
        S_DATA: begin
          if (wr_ok) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_TRL;
              data_q  <= trl_word(ovf_snap_q, frame_id_q);
            end else begin
              idx_q  <= idx_nxt;
              data_q <= READOUT_WIDTH_G'(shadow_q[idx_nxt]);
            end
          end
        end
        default: begin
          if (wr_ok) begin
            state_q    <= S_IDLE;
            frame_id_q <= frame_id_q + 16'd1;
          end
        end
      endcase
    end
  end

  assign fifo_wr_o   = wr_ok;
  assign fifo_data_o = data_q;
  assign busy_o      = (state_q != S_IDLE);
  assign trig_drop_o = drop_q;

endmodule
